// File: rtl/tpu_pkg.sv
// Shared definitions for the accumulator write-back path: width derivations,
// accumulator default width and the tile-control state encoding.
package tpu_pkg;

    localparam int ACC_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One extra address bit lets num_rows express a full-depth tile.
    function automatic int calc_addr_width(input int max_rows);
        return $clog2(max_rows) + 1;
    endfunction

    function automatic int calc_in_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/col_deskew.sv
// Per-column delay line: DEPTH registers of valid+data, or a plain wire when
// DEPTH is zero (the last column needs no delay).
module col_deskew #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk & reset;
            assign valid_o        = valid_i;
            assign data_o         = data_i;
        end else begin : g_shift
            logic [DEPTH-1:0] valid_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    valid_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q[0] <= valid_i;
                    data_q[0]  <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign valid_o = valid_q[DEPTH-1];
            assign data_o  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/accum_writeback_ctrl.sv
// Deskews systolic-array column outputs into aligned rows and read-modify-writes
// each row into accumTable (accumulate or overwrite), one tile per start pulse.
module accum_writeback_ctrl
    import tpu_pkg::*;
#(
    parameter int  DATA_WIDTH   = 8,
    parameter int  ACC_WIDTH    = ACC_WIDTH_DEFAULT,
    parameter int  SYS_ARR_COLS = 16,
    parameter int  MAX_OUT_ROWS = 1024,
    localparam int IN_WIDTH     = calc_in_width(DATA_WIDTH),
    localparam int ADDR_WIDTH   = calc_addr_width(MAX_OUT_ROWS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic [ADDR_WIDTH-1:0]             num_rows,
    input  logic                              accum_en,
    input  logic [SYS_ARR_COLS-1:0]           col_valid,
    input  logic [SYS_ARR_COLS*IN_WIDTH-1:0]  col_data,
    output logic [ADDR_WIDTH-1:0]             rd_addr,
    input  logic [SYS_ARR_COLS*ACC_WIDTH-1:0] rd_data,
    output logic                              wr_en,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic [SYS_ARR_COLS*ACC_WIDTH-1:0] wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam logic [ADDR_WIDTH:0] MAX_ROWS_W = (ADDR_WIDTH+1)'(MAX_OUT_ROWS);

    logic [SYS_ARR_COLS-1:0]           dsk_valid;
    logic [SYS_ARR_COLS*IN_WIDTH-1:0]  dsk_data;
    logic [SYS_ARR_COLS-1:0]           a_valid_q;
    logic [SYS_ARR_COLS*IN_WIDTH-1:0]  a_data_q;

    state_e                            state_q;
    logic [ADDR_WIDTH-1:0]             base_q;
    logic [ADDR_WIDTH-1:0]             num_q;
    logic [ADDR_WIDTH-1:0]             row_cnt_q;
    logic                              accum_q;
    logic                              busy_q;
    logic                              done_q;
    logic                              err_q;

    logic                              b_valid_q;
    logic [ADDR_WIDTH-1:0]             b_addr_q;
    logic [SYS_ARR_COLS*IN_WIDTH-1:0]  b_data_q;
    logic                              byp_q;
    logic [SYS_ARR_COLS*ACC_WIDTH-1:0] byp_data_q;

    logic                              row_any;
    logic                              row_ok;
    logic                              row_err;
    logic [ADDR_WIDTH:0]               addr_sum;
    logic [ADDR_WIDTH-1:0]             a_addr;

    // Column gi arrives gi cycles late, so it gets SYS_ARR_COLS-1-gi delay stages.
    genvar gi;
    generate
        for (gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_col
            col_deskew #(
                .DEPTH (SYS_ARR_COLS - 1 - gi),
                .WIDTH (IN_WIDTH)
            ) u_deskew (
                .clk     (clk),
                .reset   (reset),
                .valid_i (col_valid[gi]),
                .data_i  (col_data[gi*IN_WIDTH +: IN_WIDTH]),
                .valid_o (dsk_valid[gi]),
                .data_o  (dsk_data[gi*IN_WIDTH +: IN_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_valid_q <= '0;
            a_data_q  <= '0;
        end else begin
            a_valid_q <= dsk_valid;
            a_data_q  <= dsk_data;
        end
    end

    always_comb begin
        row_any  = |a_valid_q;
        row_ok   = (&a_valid_q) && (state_q == RUN);
        row_err  = row_any && !row_ok;
        addr_sum = {1'b0, base_q} + {1'b0, row_cnt_q};
        a_addr   = ADDR_WIDTH'(addr_sum % MAX_ROWS_W);
    end

    // The table read issued while stage B writes the same row returns stale
    // data, so the in-flight write result is captured and substituted.
    generate
        for (gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_lane
            logic [ACC_WIDTH-1:0] old_val;
            logic [ACC_WIDTH-1:0] psum_ext;
            assign old_val  = !accum_q ? '0 :
                              (byp_q ? byp_data_q[gi*ACC_WIDTH +: ACC_WIDTH]
                                     : rd_data[gi*ACC_WIDTH +: ACC_WIDTH]);
            assign psum_ext = {{(ACC_WIDTH-IN_WIDTH){b_data_q[gi*IN_WIDTH+IN_WIDTH-1]}},
                               b_data_q[gi*IN_WIDTH +: IN_WIDTH]};
            assign wr_data[gi*ACC_WIDTH +: ACC_WIDTH] = old_val + psum_ext;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            row_cnt_q  <= '0;
            accum_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            b_valid_q  <= 1'b0;
            b_addr_q   <= '0;
            b_data_q   <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            b_valid_q  <= row_ok;
            b_addr_q   <= a_addr;
            b_data_q   <= a_data_q;
            byp_q      <= row_ok && b_valid_q && (a_addr == b_addr_q);
            byp_data_q <= wr_data;
            done_q     <= 1'b0;
            if (row_err) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        num_q     <= num_rows;
                        accum_q   <= accum_en;
                        row_cnt_q <= '0;
                        err_q     <= row_err;
                        busy_q    <= 1'b1;
                        if (num_rows == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (row_ok) begin
                        row_cnt_q <= row_cnt_q + ADDR_WIDTH'(1);
                        if ((row_cnt_q + ADDR_WIDTH'(1)) == num_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // No row is accepted here, so stage B is empty after this cycle.
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr = a_addr;
    assign wr_en   = b_valid_q;
    assign wr_addr = b_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
